// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU command receiver: op codes, error-flag
// positions, framing constants and the CRC4 used over {B, A, 1'b1, op}.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_ADD     = 3'b100,
    OP_SUB     = 3'b101,
    OP_UNKNOWN = 3'b111
  } alu_op_t;

  localparam int unsigned ERR_DATA = 2;
  localparam int unsigned ERR_CRC  = 1;
  localparam int unsigned ERR_OP   = 0;

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned DATA_FRAMES = 8;

  // Serial CRC4, polynomial x^4+x+1, init 0, message consumed MSB first.
  function automatic logic [3:0] get_CRC4_d68(input logic [67:0] d);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb  = crc[3] ^ d[67 - i];
      crc = {crc[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
    end
    return crc;
  endfunction

  function automatic logic op_is_known(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_crc4_d68.sv
// Combinational CRC4 over a 68-bit message, wrapping the package function.
module alu_crc4_d68
  import alu_pkg::*;
(
  input  logic [67:0] data,
  output logic [3:0]  crc
);

  assign crc = get_CRC4_d68(data);

endmodule

// File: rtl/alu_serial_rx.sv
// Receives 8 data frames (B then A, MSB byte first) plus one control frame
// carrying op and CRC; reports a good command or a single prioritised error.
module alu_serial_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [2:0]  err_flags_o
);

  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, REPORT} state_t;

  state_t      state, next;
  logic [2:0]  bit_cnt;
  logic [3:0]  frame_cnt;
  logic        type_bit;
  logic [7:0]  payload;
  logic [63:0] data_sr;
  logic [3:0]  crc_calc;
  logic        to_report;
  logic        accept_data;
  logic [2:0]  flags;

  alu_crc4_d68 u_crc (
    .data ({data_sr, 1'b1, payload[6:4]}),
    .crc  (crc_calc)
  );

  always_comb begin
    next        = state;
    to_report   = 1'b0;
    accept_data = 1'b0;
    flags       = '0;
    unique case (state)
      IDLE:    if (!sin) next = TYPE;
      TYPE:    next = PAYLOAD;
      PAYLOAD: if (bit_cnt == 3'd7) next = STOP;
      STOP: begin
        if (!sin || type_bit || frame_cnt == 4'(DATA_FRAMES)) begin
          next      = REPORT;
          to_report = 1'b1;
          // A data frame only reaches REPORT on a framing fault or a 9th frame.
          if (!sin || !type_bit || frame_cnt != 4'(DATA_FRAMES))
            flags[ERR_DATA] = 1'b1;
          else if (crc_calc != payload[3:0])
            flags[ERR_CRC] = 1'b1;
          else if (!op_is_known(payload[6:4]))
            flags[ERR_OP] = 1'b1;
        end else begin
          next        = IDLE;
          accept_data = 1'b1;
        end
      end
      REPORT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      type_bit    <= 1'b0;
      payload     <= '0;
      data_sr     <= '0;
      a_o         <= '0;
      b_o         <= '0;
      op_o        <= '0;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      err_flags_o <= '0;
    end else begin
      state       <= next;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      err_flags_o <= '0;
      if (state == TYPE) begin
        type_bit <= sin;
        bit_cnt  <= '0;
      end
      if (state == PAYLOAD) begin
        payload <= {payload[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (accept_data) begin
        data_sr   <= {data_sr[55:0], payload};
        frame_cnt <= frame_cnt + 4'd1;
      end
      if (state == REPORT) frame_cnt <= '0;
      if (to_report) begin
        if (flags == '0) begin
          valid_o <= 1'b1;
          b_o     <= data_sr[63:32];
          a_o     <= data_sr[31:0];
          op_o    <= payload[6:4];
        end else begin
          err_o       <= 1'b1;
          err_flags_o <= flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: packet table plus hand-built corner sequences.
module tb_alu_serial_rx;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a_o, b_o;
  logic [2:0]  op_o;
  logic        valid_o, err_o;
  logic [2:0]  err_flags_o;

  alu_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .err_flags_o (err_flags_o)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, ncyc = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0;

  always @(negedge clk) begin
    ncyc++;
    if (valid_o) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = ncyc;
    end
    if (err_o) err_cnt++;
    if (valid_o && err_o) both_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [31:0] a, input logic [31:0] b, input int ndata);
    logic [63:0] w;
    w = {b, a};
    for (int i = 0; i < ndata; i++) send_frame(1'b0, w[63 - 8*i -: 8], 1'b1);
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [3:0] crc, input int ndata);
    send_data(a, b, ndata);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic wait_report(output logic got_v, output logic got_e, output logic [2:0] fl);
    got_v = 1'b0;
    got_e = 1'b0;
    fl    = '0;
    for (int i = 0; i < 2 * FRAME_BITS; i++) begin
      @(negedge clk);
      sin = 1'b1;
      if (valid_o || err_o) begin
        got_v = valid_o;
        got_e = err_o;
        fl    = err_flags_o;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  crc;
    int          ndata;
    logic        exp_valid;
    logic [2:0]  exp_flags;
    logic [31:0] exp_a, exp_b;
    logic [2:0]  exp_op;
  } vec_t;

  vec_t vecs[6];
  logic       gv, ge;
  logic [2:0] gf;
  int         vc0, ec0;

  initial begin
    // CRC values worked by hand as remainder of M(x)*x^4 mod x^4+x+1.
    vecs[0] = '{"good_add",  32'h1, 32'h2, 3'b100, 4'hC, 8, 1'b1, 3'b000, 32'h1, 32'h2, 3'b100};
    vecs[1] = '{"bad_crc",   32'h1, 32'h2, 3'b100, 4'hD, 8, 1'b0, 3'b010, 32'h1, 32'h2, 3'b100};
    vecs[2] = '{"short_pkt", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 4'h0, 7, 1'b0, 3'b100, 32'h1, 32'h2, 3'b100};
    vecs[3] = '{"bad_op",    32'h0, 32'h0, 3'b010, 4'hD, 8, 1'b0, 3'b001, 32'h1, 32'h2, 3'b100};
    vecs[4] = '{"good_or",   32'h0, 32'h0, 3'b001, 4'h8, 8, 1'b1, 3'b000, 32'h0, 32'h0, 3'b001};
    vecs[5] = '{"good_sub",  32'h0, 32'h0, 3'b101, 4'h4, 8, 1'b1, 3'b000, 32'h0, 32'h0, 3'b101};

    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a", 64'(a_o), 64'h0);
    chk("rst_b", 64'(b_o), 64'h0);
    chk("rst_op", 64'(op_o), 64'h0);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_flags", 64'(err_flags_o), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_packet(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].crc, vecs[i].ndata);
      wait_report(gv, ge, gf);
      chk({vecs[i].name, "_valid"}, 64'(gv), 64'(vecs[i].exp_valid));
      chk({vecs[i].name, "_err"}, 64'(ge), 64'(!vecs[i].exp_valid));
      chk({vecs[i].name, "_flags"}, 64'(gf), 64'(vecs[i].exp_flags));
      chk({vecs[i].name, "_a"}, 64'(a_o), 64'(vecs[i].exp_a));
      chk({vecs[i].name, "_b"}, 64'(b_o), 64'(vecs[i].exp_b));
      chk({vecs[i].name, "_op"}, 64'(op_o), 64'(vecs[i].exp_op));
    end

    // Ninth data frame is rejected; the following control frame starts a fresh, short packet.
    send_data(32'h0, 32'h0, 8);
    send_frame(1'b0, 8'hA5, 1'b1);
    wait_report(gv, ge, gf);
    chk("ninth_err", 64'(ge), 64'h1);
    chk("ninth_flags", 64'(gf), 64'h4);
    send_frame(1'b1, {1'b0, 3'b101, 4'h4}, 1'b1);
    wait_report(gv, ge, gf);
    chk("orphan_ctl_err", 64'(ge), 64'h1);
    chk("orphan_ctl_flags", 64'(gf), 64'h4);
    chk("orphan_ctl_op", 64'(op_o), 64'h5);

    send_frame(1'b0, 8'h3C, 1'b0);
    wait_report(gv, ge, gf);
    chk("stop0_err", 64'(ge), 64'h1);
    chk("stop0_flags", 64'(gf), 64'h4);

    // Reset in the middle of the 5th data frame.
    send_data(32'hFFFFFFFF, 32'h0, 4);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_a", 64'(a_o), 64'h0);
    chk("midrst_op", 64'(op_o), 64'h0);
    vc0 = valid_cnt;
    ec0 = err_cnt;
    send_packet(32'hFFFFFFFF, 32'h0, 3'b000, 4'h4, 8);
    wait_report(gv, ge, gf);
    @(negedge clk);
    chk("after_rst_valid_cnt", 64'(valid_cnt - vc0), 64'h1);
    chk("after_rst_err_cnt", 64'(err_cnt - ec0), 64'h0);
    chk("after_rst_a", 64'(a_o), 64'hFFFFFFFF);
    chk("after_rst_b", 64'(b_o), 64'h0);
    chk("after_rst_op", 64'(op_o), 64'h0);

    // Back-to-back: the bit driven during REPORT is ignored, next start bit follows it.
    vc0 = valid_cnt;
    send_packet(32'h1, 32'h2, 3'b100, 4'hC, 8);
    send_bit(1'b1);
    send_packet(32'h0, 32'h0, 3'b001, 4'h8, 8);
    wait_report(gv, ge, gf);
    @(negedge clk);
    chk("b2b_valid_cnt", 64'(valid_cnt - vc0), 64'h2);
    chk("b2b_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'd100);
    chk("b2b_op", 64'(op_o), 64'h1);
    chk("b2b_a", 64'(a_o), 64'h0);

    chk("valid_err_overlap", 64'(both_cnt), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
